// File: rtl/bju_pipe.sv
// Branch/jump resolution unit: resolves JAL/JALR/conditional branches, compares against the
// frontend prediction, emits a registered result/redirect and queues predictor training records.
module bju_pipe #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned PC_WIDTH     = 64,
    parameter int unsigned TARGET_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH  = 9,
    parameter int unsigned SLOTS        = 4,
    parameter int unsigned UPDQ_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [XLEN-1:0]                     src1,
    input  logic [XLEN-1:0]                     src2,
    input  logic [XLEN-1:0]                     imm,
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [5:0]                          cx_type,
    input  logic                                is_unsigned,
    input  logic                                predict_taken,
    input  logic [TARGET_WIDTH-1:0]             predict_target,
    output logic                                out_valid,
    output logic [XLEN-1:0]                     out_dest,
    output logic                                redirect_valid,
    output logic [PC_WIDTH-1:0]                 redirect_target,
    output logic                                upd_valid,
    input  logic                                upd_ready,
    output logic [INDEX_WIDTH-1:0]              upd_index,
    output logic [$clog2(SLOTS)-1:0]            upd_slot,
    output logic                                upd_inc,
    output logic                                upd_dec,
    output logic                                upd_btb_we,
    output logic [SLOTS*TARGET_WIDTH:0]         upd_btb_wmask,
    output logic [SLOTS*TARGET_WIDTH:0]         upd_btb_din,
    input  logic                                pmu_clear,
    output logic [CNT_WIDTH-1:0]                pmu_cnt1,
    output logic [CNT_WIDTH-1:0]                pmu_cnt2,
    output logic [CNT_WIDTH-1:0]                pmu_cnt3,
    output logic [CNT_WIDTH-1:0]                pmu_cnt4,
    output logic [CNT_WIDTH-1:0]                pmu_cnt5
);

    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned TW = TARGET_WIDTH;
    localparam int unsigned AW = (XLEN > PC_WIDTH) ? XLEN : PC_WIDTH;
    localparam int unsigned PW = $clog2(UPDQ_DEPTH);
    localparam int unsigned CW = $clog2(UPDQ_DEPTH) + 1;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [SW-1:0]          slot;
        logic                   inc;
        logic                   dec;
        logic                   btb_we;
        logic [TW-1:0]          tgt;
    } upd_rec_t;

    logic                eq, lt, cond_taken, act_taken, tgt_hit, accept, redirect;
    logic [AW-1:0]       jalr_sum, pc_sum;
    logic [PC_WIDTH-1:0] target, pc_plus4;
    logic [4:0]          sit;
    upd_rec_t            rec, head;

    // Stage 0: resolution and classification, all combinational
    always_comb begin
        eq         = (src1 == src2);
        lt         = is_unsigned ? (src1 < src2) : ($signed(src1) < $signed(src2));
        cond_taken = (cx_type[2] & eq) | (cx_type[3] & ~eq) | (cx_type[4] & lt) | (cx_type[5] & ~lt);
        act_taken  = cx_type[0] | cx_type[1] | cond_taken;
        jalr_sum   = AW'(src1) + AW'(imm);
        pc_sum     = AW'(pc) + AW'(imm);
        target     = cx_type[1] ? (jalr_sum[PC_WIDTH-1:0] & ~PC_WIDTH'(1)) : pc_sum[PC_WIDTH-1:0];
        pc_plus4   = pc + PC_WIDTH'(4);
        tgt_hit    = (target[TW-1:0] == predict_target);
        sit[0]     = act_taken & predict_taken & tgt_hit;
        sit[1]     = act_taken & predict_taken & ~tgt_hit;
        sit[2]     = act_taken & ~predict_taken;
        sit[3]     = ~act_taken & predict_taken;
        sit[4]     = ~act_taken & ~predict_taken;
        redirect   = sit[1] | sit[2] | sit[3];
        rec.index  = pc[INDEX_WIDTH+SW+1:SW+2];
        rec.slot   = pc[SW+1:2];
        rec.inc    = sit[0] | sit[1] | sit[2];
        rec.dec    = sit[3] | sit[4];
        rec.btb_we = sit[1] | sit[2];
        rec.tgt    = target[TW-1:0];
    end

    // Result register
    logic                out_valid_q, redirect_valid_q;
    logic [XLEN-1:0]     out_dest_q;
    logic [PC_WIDTH-1:0] redirect_target_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q       <= 1'b0;
            redirect_valid_q  <= 1'b0;
            out_dest_q        <= '0;
            redirect_target_q <= '0;
        end else begin
            out_valid_q      <= accept;
            redirect_valid_q <= accept & redirect;
            if (accept)
                out_dest_q <= XLEN'(pc_plus4);
            if (accept && redirect)
                redirect_target_q <= sit[3] ? pc_plus4 : target;
        end
    end

    assign out_valid       = out_valid_q;
    assign redirect_valid  = redirect_valid_q;
    assign out_dest        = out_dest_q;
    assign redirect_target = redirect_target_q;

    // Update FIFO: masks/data are rebuilt from the stored target at the head
    upd_rec_t      fifo_q [UPDQ_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, deq;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CW'(UPDQ_DEPTH));
    assign accept   = in_valid & in_ready & ~flush;
    assign deq      = ~empty & upd_ready;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (accept)
            wr_d = wr_q + PW'(1);
        if (deq)
            rd_d = rd_q + PW'(1);
        if (accept && !deq)
            count_d = count_q + CW'(1);
        else if (!accept && deq)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept)
            fifo_q[wr_q] <= rec;
    end

    always_comb begin
        head          = fifo_q[rd_q];
        upd_valid     = ~empty;
        upd_index     = '0;
        upd_slot      = '0;
        upd_inc       = 1'b0;
        upd_dec       = 1'b0;
        upd_btb_we    = 1'b0;
        upd_btb_wmask = '0;
        upd_btb_din   = '0;
        if (!empty) begin
            upd_index  = head.index;
            upd_slot   = head.slot;
            upd_inc    = head.inc;
            upd_dec    = head.dec;
            upd_btb_we = head.btb_we;
            if (head.btb_we) begin
                upd_btb_wmask[SLOTS*TW] = 1'b1;
                upd_btb_din[SLOTS*TW]   = 1'b1;
                for (int unsigned s = 0; s < SLOTS; s++) begin
                    if (head.slot == SW'(s)) begin
                        upd_btb_wmask[s*TW +: TW] = '1;
                        upd_btb_din[s*TW +: TW]   = head.tgt;
                    end
                end
            end
        end
    end

    // PMU counters: clear wins over increment, increments saturate
    logic [CNT_WIDTH-1:0] cnt_q [5];
    logic [CNT_WIDTH-1:0] cnt_d [5];

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pmu_clear)
                cnt_d[i] = '0;
            else if (accept && sit[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 5; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign pmu_cnt1 = cnt_q[0];
    assign pmu_cnt2 = cnt_q[1];
    assign pmu_cnt3 = cnt_q[2];
    assign pmu_cnt4 = cnt_q[3];
    assign pmu_cnt5 = cnt_q[4];

endmodule

// File: tb/tb_bju_pipe.sv
// Scoreboard bench for bju_pipe: directed cases plus random traffic against an outcome-level model.
module tb_bju_pipe;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clock = 1'b0;
    logic          reset_n, flush, in_valid, in_ready, is_unsigned, predict_taken;
    logic [63:0]   src1, src2, imm, pc, out_dest, redirect_target;
    logic [5:0]    cx_type;
    logic [31:0]   predict_target;
    logic          out_valid, redirect_valid, upd_valid, upd_ready;
    logic [8:0]    upd_index;
    logic [1:0]    upd_slot;
    logic          upd_inc, upd_dec, upd_btb_we, pmu_clear;
    logic [128:0]  upd_btb_wmask, upd_btb_din;
    logic [CW-1:0] pmu_cnt1, pmu_cnt2, pmu_cnt3, pmu_cnt4, pmu_cnt5;

    bju_pipe #(.XLEN(64), .PC_WIDTH(64), .TARGET_WIDTH(32), .INDEX_WIDTH(9),
               .SLOTS(4), .UPDQ_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .pc(pc), .cx_type(cx_type), .is_unsigned(is_unsigned),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .out_valid(out_valid), .out_dest(out_dest), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_index(upd_index), .upd_slot(upd_slot), .upd_inc(upd_inc), .upd_dec(upd_dec),
        .upd_btb_we(upd_btb_we), .upd_btb_wmask(upd_btb_wmask), .upd_btb_din(upd_btb_din),
        .pmu_clear(pmu_clear), .pmu_cnt1(pmu_cnt1), .pmu_cnt2(pmu_cnt2), .pmu_cnt3(pmu_cnt3),
        .pmu_cnt4(pmu_cnt4), .pmu_cnt5(pmu_cnt5)
    );

    always #5 clock = ~clock;

    typedef struct { int due; logic [63:0] dest; logic rv; logic [63:0] rt; } out_e;
    typedef struct { logic [8:0] idx; logic [1:0] slot; logic inc, dec, we; logic [128:0] wm, din; } upd_e;

    out_e exp_out[$];
    upd_e exp_upd[$];
    int tests = 0, fails = 0, cyc = 0, mcount = 0;
    logic [CW-1:0] mcnt [1:5];
    logic rdy_g = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Outcome-level reference: classify, then derive result and training record
    function automatic void model(input logic [5:0] ty, input logic uns, input logic [63:0] a, b, im, p,
                                  input logic pt, input logic [31:0] ptg,
                                  output out_e oe, output upd_e ue, output int s);
        logic tk;
        logic [63:0] tgt;
        logic [128:0] one, fld, tv;
        tk = 1'b1;
        if (ty[2]) tk = (a == b);
        if (ty[3]) tk = (a != b);
        if (ty[4]) tk = uns ? (a < b) : ($signed(a) < $signed(b));
        if (ty[5]) tk = uns ? (a >= b) : ($signed(a) >= $signed(b));
        tgt = ty[1] ? ((a + im) & ~64'd1) : (p + im);
        if (tk) s = pt ? ((tgt[31:0] == ptg) ? 1 : 2) : 3;
        else    s = pt ? 4 : 5;
        oe.dest = p + 64'd4;
        oe.rv   = (s == 2) || (s == 3) || (s == 4);
        oe.rt   = (s == 4) ? p + 64'd4 : tgt;
        ue.idx  = p[12:4];
        ue.slot = p[3:2];
        ue.inc  = (s <= 3);
        ue.dec  = (s >= 4);
        ue.we   = (s == 2) || (s == 3);
        one = 129'd1;
        fld = {97'd0, 32'hFFFF_FFFF};
        tv  = {97'd0, tgt[31:0]};
        ue.wm  = ue.we ? ((one << 128) | (fld << (ue.slot * 32))) : '0;
        ue.din = ue.we ? ((one << 128) | (tv << (ue.slot * 32))) : '0;
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input logic v, f, input logic [5:0] ty, input logic uns,
                        input logic [63:0] a, b, im, p, input logic pt, input logic [31:0] ptg,
                        input logic clr, rdy);
        bit acc, deq;
        int s;
        out_e oe;
        upd_e ue;
        in_valid = v; flush = f; cx_type = ty; is_unsigned = uns; src1 = a; src2 = b; imm = im;
        pc = p; predict_taken = pt; predict_target = ptg; pmu_clear = clr; upd_ready = rdy;
        acc = v && !f && (mcount < DEPTH);
        deq = rdy && (mcount > 0);
        s = 0;
        if (acc) begin
            model(ty, uns, a, b, im, p, pt, ptg, oe, ue, s);
            oe.due = cyc + 1;
            exp_out.push_back(oe);
            exp_upd.push_back(ue);
        end
        @(posedge clock); #1;
        mcount = mcount + int'(acc) - int'(deq);
        if (clr) begin
            for (int i = 1; i <= 5; i++) mcnt[i] = '0;
        end else if (acc && mcnt[s] != CMAX) begin
            mcnt[s] = mcnt[s] + 1'b1;
        end
        chk("in_ready", in_ready, mcount < DEPTH);
        chk("pmu_cnt1", pmu_cnt1, mcnt[1]);
        chk("pmu_cnt2", pmu_cnt2, mcnt[2]);
        chk("pmu_cnt3", pmu_cnt3, mcnt[3]);
        chk("pmu_cnt4", pmu_cnt4, mcnt[4]);
        chk("pmu_cnt5", pmu_cnt5, mcnt[5]);
    endtask

    task automatic br(input logic [5:0] ty, input logic uns, input logic [63:0] a, b, im, p,
                      input logic pt, input logic [31:0] ptg);
        step(1'b1, 1'b0, ty, uns, a, b, im, p, pt, ptg, 1'b0, rdy_g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 6'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 32'd0, 1'b0, rdy_g);
    endtask

    function automatic logic [63:0] rval();
        case ($urandom_range(0, 4))
            0: rval = 64'd0;
            1: rval = 64'd1;
            2: rval = '1;
            3: rval = 64'h8000_0000_0000_0000;
            default: rval = {$urandom, $urandom};
        endcase
    endfunction

    // Result monitor: every expected result must appear exactly on its due cycle
    always @(negedge clock) begin
        if (reset_n) begin
            if (exp_out.size() != 0 && exp_out[0].due == cyc) begin
                out_e e;
                e = exp_out.pop_front();
                chk("out_valid", out_valid, 1'b1);
                chk("out_dest", out_dest, e.dest);
                chk("redirect_valid", redirect_valid, e.rv);
                if (e.rv) chk("redirect_target", redirect_target, e.rt);
            end else if (out_valid || redirect_valid) begin
                tests++; fails++;
                $display("FAIL spurious_out: got out_valid=%0b redirect_valid=%0b expected 0", out_valid, redirect_valid);
            end
        end
    end

    // Update monitor: head must match the oldest outstanding record; empty head is all zero
    always @(negedge clock) begin
        if (reset_n) begin
            if (upd_valid) begin
                if (exp_upd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_upd: got upd_valid=1 expected 0");
                end else begin
                    chk("upd_index", upd_index, exp_upd[0].idx);
                    chk("upd_slot", upd_slot, exp_upd[0].slot);
                    chk("upd_incdec", {upd_inc, upd_dec}, {exp_upd[0].inc, exp_upd[0].dec});
                    chk("upd_btb_we", upd_btb_we, exp_upd[0].we);
                    chk("upd_btb_wmask", upd_btb_wmask, exp_upd[0].wm);
                    chk("upd_btb_din", upd_btb_din, exp_upd[0].din);
                    if (upd_ready) void'(exp_upd.pop_front());
                end
            end else begin
                chk("upd_empty_payload", {upd_index, upd_slot, upd_inc, upd_dec, upd_btb_we, upd_btb_wmask, upd_btb_din}, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ty;
        logic [63:0] a, b, im, p;
        logic [31:0] ptg;
        for (int i = 1; i <= 5; i++) mcnt[i] = '0;
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; cx_type = '0; is_unsigned = 1'b0;
        src1 = '0; src2 = '0; imm = '0; pc = '0; predict_taken = 1'b0; predict_target = '0;
        pmu_clear = 1'b0; upd_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_out_dest", out_dest, 64'd0);
        chk("rst_redirect_target", redirect_target, 64'd0);
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_pmu", {pmu_cnt1, pmu_cnt2, pmu_cnt3, pmu_cnt4, pmu_cnt5}, '0);
        reset_n = 1'b1;
        idle(1);

        rdy_g = 1'b1;
        br(6'b000100, 1'b0, 64'd5, 64'd5, 64'h40, 64'h1000, 1'b1, 32'h1040);
        br(6'b010000, 1'b0, '1, 64'd1, 64'h80, 64'h2004, 1'b0, 32'd0);
        br(6'b010000, 1'b1, '1, 64'd1, 64'h80, 64'h2008, 1'b0, 32'd0);
        br(6'b000010, 1'b0, 64'h2003, 64'd0, 64'd0, 64'h4000, 1'b1, 32'h3000);
        br(6'b001000, 1'b0, 64'd7, 64'd7, 64'h100, 64'h100C, 1'b1, 32'h110C);
        br(6'b100000, 1'b1, 64'd3, 64'd9, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3008, 1'b1, 32'h2FF8);
        br(6'b000001, 1'b0, 64'd0, 64'd0, 64'h20, 64'h5000, 1'b1, 32'h5020);
        idle(2);

        // Fill the FIFO with the predictor stalled, then drain with flush active
        rdy_g = 1'b0;
        for (int i = 0; i < 5; i++)
            br(6'b000100, 1'b0, 64'd1, 64'd2, 64'h10, 64'h6000 + 64'(i * 4), 1'b1, 32'h6010);
        rdy_g = 1'b1;
        step(1'b1, 1'b1, 6'b000001, 1'b0, 64'd0, 64'd0, 64'h8, 64'h7000, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(5);

        // Saturation, then clear coinciding with an accept
        for (int i = 0; i < 18; i++)
            br(6'b000100, 1'b0, 64'd9, 64'd9, 64'h40, 64'h8000, 1'b1, 32'h8040);
        step(1'b1, 1'b0, 6'b000100, 1'b0, 64'd9, 64'd9, 64'h40, 64'h8000, 1'b1, 32'h8040, 1'b1, 1'b1);
        idle(3);

        // Asynchronous reset with records still queued and a result in flight
        rdy_g = 1'b0;
        for (int i = 0; i < 3; i++)
            br(6'b000001, 1'b0, 64'd0, 64'd0, 64'h40, 64'h9000, 1'b0, 32'd0);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("arst_upd_valid", upd_valid, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_pmu1", pmu_cnt1, '0);
        exp_out.delete(); exp_upd.delete(); mcount = 0;
        for (int i = 1; i <= 5; i++) mcnt[i] = '0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);

        for (int n = 0; n < 400; n++) begin
            ty = 6'b000001 << $urandom_range(0, 5);
            a = rval();
            b = ($urandom_range(0, 3) == 0) ? a : rval();
            im = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 4095)) - 64'd2048 : {$urandom, $urandom};
            p = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: ptg = 32'(p + im);
                1: ptg = 32'((a + im) & ~64'd1);
                default: ptg = $urandom;
            endcase
            rdy_g = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, ty, 1'($urandom_range(0, 1)),
                 a, b, im, p, 1'($urandom_range(0, 1)), ptg, $urandom_range(0, 49) == 0, rdy_g);
        end

        rdy_g = 1'b1;
        idle(8);
        chk("final_out_queue_empty", 64'(exp_out.size()), 64'd0);
        chk("final_upd_queue_empty", 64'(exp_upd.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bju_pipe.md
# bju_pipe

Pipelined, parametrised branch/jump resolution unit for the backend EXU. It resolves JAL/JALR/conditional branches and compares the outcome against the frontend prediction. It emits a registered writeback/redirect one cycle after accept. BHT/BTB training records are queued in an internal update FIFO with a valid/ready handshake toward the predictor, and saturating PMU counters track the five prediction-outcome classes.

## Interface
Parameters:
- XLEN, 64, width of src1/src2/imm/dest
- PC_WIDTH, 64, PC width
- TARGET_WIDTH, 32, BTB target width; prediction compare uses low TARGET_WIDTH bits
- INDEX_WIDTH, 9, BHT/BTB set-index width
- SLOTS, 4, instructions per set (power of 2, ≥2); SW = log2(SLOTS)
- UPDQ_DEPTH, 4, update FIFO entries (power of 2, ≥2)
- CNT_WIDTH, 32, PMU counter width

Ports:
- clock  in  1  clock
- reset_n  in  1  reset: asynchronous, active-low
- flush  in  1  pipeline kill
- in_valid  in  1  request valid
- in_ready  out  1  = ~updq_full
- src1, src2, imm  in  XLEN  operands and immediate
- pc  in  PC_WIDTH  instruction PC
- cx_type  in  6  one-hot: JAL, JALR, BEQ, BNE, BLT, BGE (bit0 to bit5)
- is_unsigned  in  1  BLT→BLTU, BGE→BGEU
- predict_taken  in  1  frontend predicted taken
- predict_target  in  TARGET_WIDTH  frontend predicted target
- out_valid  out  1  result valid (1-cycle pulse)
- out_dest  out  XLEN  pc+4, zero-extended
- redirect_valid  out  1  mispredict redirect
- redirect_target  out  PC_WIDTH  redirect PC
- upd_valid / upd_ready  out / in  1  update handshake
- upd_index  out  INDEX_WIDTH  = pc[INDEX_WIDTH+SW+1 : SW+2]
- upd_slot  out  SW  = pc[SW+1:2]
- upd_inc, upd_dec  out  1  BHT counter direction
- upd_btb_we  out  1  BTB write
- upd_btb_wmask, upd_btb_din  out  1+SLOTS*TARGET_WIDTH  MSB = set valid bit; slot s occupies bits [(s+1)*TW-1 : s*TW]
- pmu_clear  in  1  synchronous clear of counters
- pmu_cnt1..pmu_cnt5  out  CNT_WIDTH  situation counters

## Operation
- accept = in_valid & in_ready & ~flush. Stage 0 is combinational, and all effects are registered on the accept edge.
- Branch taken conditions:
  - BEQ: eq. BNE: ~eq.
  - BLT: signed <. BGE: signed ≥.
  - BLTU: unsigned <. BGEU: unsigned ≥.
  - JAL/JALR: always taken.
- act_taken = JAL | JALR | cond_taken.
- Targets:
  - JALR: (src1+imm) with bit0 cleared.
  - Others: pc+imm.
  - Both are truncated to PC_WIDTH.
- Situations (exactly one per accept):
  - S1: taken, pred taken, tgt[TW-1:0]==predict_target
  - S2: taken, pred taken, target mismatch
  - S3: taken, pred not taken
  - S4: not taken, pred taken
  - S5: not taken, pred not taken
- Redirect:
  - S2/S3: redirect to the computed target.
  - S4: redirect to pc+4.
  - S1/S5: no redirect.
- Update record (enqueued on every accept):
  - inc = S1|S2|S3; dec = S4|S5.
  - btb_we = S2|S3.
  - wmask: MSB plus the slot field of upd_slot set, everything else zero.
  - din: MSB=1 plus the target in the selected slot, everything else zero.
  - When btb_we=0, wmask/din are zero.
- Update FIFO:
  - Circular buffer with count.
  - Head is presented on upd_*. All upd_* payloads are 0 when empty.
  - Dequeue on upd_valid & upd_ready.
  - Full: in_ready=0, so no enqueue occurs while full.
  - Simultaneous enqueue+dequeue (not full) leaves count unchanged.
- flush:
  - Blocks accept in the same cycle.
  - Clears out_valid/redirect_valid on the next edge.
  - Does not drop queued updates.
- PMU:
  - On accept, increment cntN for the matched situation.
  - Counters saturate at all-ones.
  - pmu_clear has priority over increment.

## Timing
- Latency is 1 cycle, accept edge to out_valid/redirect_valid. Outputs hold for one cycle, then return to 0 unless another accept occurs.
- There is no output backpressure.
- An accepted record is visible on upd_valid the cycle after accept. An empty FIFO has no bypass.
- Reset values:
  - out_valid, redirect_valid, out_dest, redirect_target: 0
  - FIFO empty, upd_valid=0, all upd_* payloads 0
  - in_ready=1
  - all PMU counters 0
- Reset asserted mid-operation discards the FIFO contents and in-flight results immediately (asynchronous).

## Test plan
- BEQ, pc=0x1000, src1=src2=5, imm=0x40, predict_taken=1, predict_target=0x1040 → out_valid next cycle, out_dest=0x1004, no redirect; update: index=0x100, slot=0, inc=1, btb_we=0; pmu_cnt1=1.
- BLT vs BLTU, src1=all-ones, src2=1, predict_taken=0:
  - BLT: taken → redirect to pc+imm, btb_we=1, wmask MSB + slot field set.
  - BLTU: not taken → no redirect, dec=1, pmu_cnt5++.
- JALR, src1=0x2003, imm=0, predict_taken=1, predict_target=0x3000 → redirect_target=0x2002 (bit0 cleared), S2, pmu_cnt2=1.
- Not-taken BNE predicted taken at pc=0x100C → redirect_target=0x1010, dec=1, slot=3.
- Hold upd_ready=0 and issue 5 back-to-back accepts with UPDQ_DEPTH=4:
  - in_ready drops after the 4th accept.
  - Raise upd_ready: entries drain in order and in_ready returns.
  - Assert flush with in_valid: no out_valid, count unchanged.
- Force a counter to all-ones: it stays there; pmu_clear together with an accept → 0.
